// File: rtl/loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
// Used by imem_loader and word_packer via import loader_pkg::*.
package loader_pkg;

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    localparam int CNT_W  = 16;
    localparam int CSUM_W = 8;

    // States in which the loader takes bytes from the link.
    function automatic logic takes_bytes(loader_state_t s);
        return (s == S_CNT_HI) || (s == S_CNT_LO) ||
               (s == S_DATA)   || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into big-endian 32-bit words.
// Ports: clk, reset (async active-low), clear, push, din[7:0] -> word[31:0], word_valid.
import loader_pkg::*;

module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] sh;
    logic [1:0]  cnt;

    // The 4th byte completes the word combinationally so the
    // owner can register it on the same edge it is accepted.
    assign word       = {sh, din};
    assign word_valid = push && (cnt == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sh  <= '0;
            cnt <= '0;
        end else if (push) begin
            sh  <= {sh[15:0], din};
            cnt <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: byte frame (count, data, checksum) -> sequential imem word writes.
// Ports: clk, reset(n), in_valid/in_data/in_ready, mem_we/addr/wd, cpu_reset, done, error.
import loader_pkg::*;

module imem_loader #(
    parameter int AW        = 14,
    parameter int MAX_WORDS = 16384,
    parameter int TIMEOUT   = 100000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wd,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    // Idle counter only has to reach TIMEOUT-1.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    loader_state_t     state;
    loader_state_t     state_n;
    logic [7:0]        cnt_hi;
    logic [CNT_W-1:0]  n_words;
    logic [CNT_W-1:0]  widx;
    logic [CNT_W-1:0]  n_rx;
    logic [CSUM_W-1:0] sum;
    logic [CSUM_W-1:0] sum_n;
    logic [TW-1:0]     idle;
    logic              acc;
    logic              counting;
    logic              timeout_hit;
    logic              push;
    logic [31:0]       word;
    logic              wv;

    assign acc      = in_valid && in_ready;
    assign n_rx     = {cnt_hi, in_data};
    assign sum_n    = sum + in_data;
    assign push     = acc && (state == S_DATA);
    assign counting = (state == S_CNT_LO) || (state == S_DATA) ||
                      (state == S_CSUM);

    assign timeout_hit = (TIMEOUT != 0) && counting && !acc &&
                         (idle == TW'(TIMEOUT - 1));

    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);
    assign cpu_reset = (state != S_DONE);

    // Leaving S_DATA (normally or by timeout) drops any partial word.
    word_packer u_pack (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != S_DATA),
        .push       (push),
        .din        (in_data),
        .word       (word),
        .word_valid (wv)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            S_CNT_HI: begin
                if (acc) state_n = S_CNT_LO;
            end
            S_CNT_LO: begin
                if (acc) begin
                    if (n_rx == '0 || 32'(n_rx) > MAX_WORDS)
                        state_n = S_ERR;
                    else
                        state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (wv && widx == n_words - 1'b1) state_n = S_CSUM;
            end
            S_CSUM: begin
                if (acc) state_n = (sum_n == '0) ? S_DONE : S_ERR;
            end
            S_DONE: state_n = S_DONE;
            S_ERR:  state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
        if (timeout_hit) state_n = S_ERR;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_CNT_HI;
            in_ready <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_wd   <= '0;
            cnt_hi   <= '0;
            n_words  <= '0;
            widx     <= '0;
            sum      <= '0;
            idle     <= '0;
        end else begin
            state    <= state_n;
            in_ready <= takes_bytes(state_n);
            mem_we   <= wv;

            if (wv) begin
                mem_wd   <= word;
                mem_addr <= widx[AW-1:0];
                widx     <= widx + 1'b1;
            end

            if (acc && state == S_CNT_HI) cnt_hi  <= in_data;
            if (acc && state == S_CNT_LO) n_words <= n_rx;
            if (push)                     sum     <= sum_n;

            if (acc || !counting)
                idle <= '0;
            else if (!timeout_hit)
                idle <= idle + 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad frames, count limits,
// timeout, mid-load reset and a gapped 16-word image.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int nwr   = 0;

    logic [13:0] wa [64];
    logic [31:0] wd [64];
    logic [31:0] img [16];

    imem_loader #(.AW(14), .MAX_WORDS(16384), .TIMEOUT(50)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we && nwr < 64) begin
            wa[nwr] = mem_addr;
            wd[nwr] = mem_wd;
            nwr = nwr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Drive one byte; returns 1ns after the accepting edge.
    task automatic send(input logic [7:0] b);
        int k;
        k = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout obs=%h exp=accepted", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nwr   = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] s;
        in_valid = 1'b0;
        in_data  = '0;
        reset    = 1'b0;
        #3;
        chk("rst_ready", in_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wd", mem_wd, 0);
        chk("rst_cpu", cpu_reset, 1);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        do_reset();
        chk("ready_up", in_ready, 1);

        // good 2-word frame; data sum 0x0C -> csum 0xF4
        send(8'h00); send(8'h02);
        send(8'h11); send(8'h11); send(8'hFF); send(8'hFF);
        chk("w0_we", mem_we, 1);
        chk("w0_addr", mem_addr, 0);
        chk("w0_wd", mem_wd, 32'h1111FFFF);
        send(8'hAA); send(8'hAA); send(8'hCC); send(8'hCC);
        chk("w1_we", mem_we, 1);
        chk("w1_addr", mem_addr, 1);
        chk("w1_wd", mem_wd, 32'hAAAACCCC);
        chk("pre_cpu", cpu_reset, 1);
        send(8'hF4);
        chk("ok_done", done, 1);
        chk("ok_cpu", cpu_reset, 0);
        chk("ok_ready", in_ready, 0);
        chk("ok_err", error, 0);
        chk("ok_we_off", mem_we, 0);
        @(negedge clk);
        chk("ok_nwr", nwr, 2);

        // same frame, wrong checksum
        do_reset();
        send(8'h00); send(8'h02);
        send(8'h11); send(8'h11); send(8'hFF); send(8'hFF);
        send(8'hAA); send(8'hAA); send(8'hCC); send(8'hCC);
        send(8'h1C);
        chk("bad_err", error, 1);
        chk("bad_done", done, 0);
        chk("bad_cpu", cpu_reset, 1);
        chk("bad_ready", in_ready, 0);

        // zero count
        do_reset();
        send(8'h00); send(8'h00);
        chk("n0_err", error, 1);
        chk("n0_ready", in_ready, 0);

        // count 16385 rejected
        do_reset();
        send(8'h40); send(8'h01);
        chk("nbig_err", error, 1);
        @(negedge clk);
        chk("nbig_nwr", nwr, 0);

        // count 16384 accepted
        do_reset();
        send(8'h40); send(8'h00);
        chk("nmax_err", error, 0);
        chk("nmax_ready", in_ready, 1);

        // timeout after partial word
        do_reset();
        send(8'h00); send(8'h01); send(8'hDE); send(8'hAD);
        repeat (45) @(negedge clk);
        chk("to_early", error, 0);
        repeat (10) @(negedge clk);
        chk("to_err", error, 1);
        @(negedge clk); in_valid = 1'b1; in_data = 8'hBE;
        @(negedge clk); in_data = 8'hAF;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        chk("to_nwr", nwr, 0);
        chk("to_ready", in_ready, 0);
        chk("to_cpu", cpu_reset, 1);

        // reset in the middle of a load
        do_reset();
        send(8'h00); send(8'h02);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hAF);
        chk("mid_we", mem_we, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_we0", mem_we, 0);
        chk("mid_addr", mem_addr, 0);
        chk("mid_wd", mem_wd, 0);
        chk("mid_ready", in_ready, 0);
        chk("mid_cpu", cpu_reset, 1);
        @(negedge clk);
        reset = 1'b1;
        nwr   = 0;
        @(negedge clk);
        // DE+AD+BE+AF = 0x2F8 -> csum 0x08
        send(8'h00); send(8'h01);
        send(8'hDE); send(8'hAD); send(8'hBE); send(8'hAF);
        send(8'h08);
        chk("re_done", done, 1);
        @(negedge clk);
        chk("re_nwr", nwr, 1);
        chk("re_addr", wa[0], 0);
        chk("re_wd", wd[0], 32'hDEADBEAF);

        // 16-word image with random gaps
        do_reset();
        s = 8'h00;
        send(8'h00); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            img[i] = $urandom;
            for (int j = 3; j >= 0; j--) begin
                repeat ($urandom_range(0, 8)) @(negedge clk);
                send(img[i][j*8 +: 8]);
                s = s + img[i][j*8 +: 8];
            end
        end
        send(8'h00 - s);
        chk("img_done", done, 1);
        @(negedge clk);
        chk("img_nwr", nwr, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("img_a%0d", i), wa[i], i);
            chk($sformatf("img_d%0d", i), wd[i], img[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
